// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and legal parameter ranges.
// Intended to be reused by the companion uart_rx.
package uart_tx_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 8;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int OVERSAMPLE_MIN = 2;
    localparam int OVERSAMPLE_MAX = 16;

    // Counter widths sized for the largest legal configuration.
    localparam int TICK_W = 4;
    localparam int BIT_W  = 3;

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: start, DATA_BITS LSB-first, optional parity (UART_PARITY_EN), stop bit(s).
// Latency: tx drops to the start level one clk after the tx_valid/tx_ready handshake.
// Backpressure: tx_ready is high only in IDLE; requests while busy are ignored.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
`ifdef UART_PARITY_EN
    ,
    input  logic                 parity_odd
`endif
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS out of range");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
        $error("uart_tx: OVERSAMPLE out of range");
    end

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_d;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
`ifdef UART_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign bit_end   = s_tick && (tick_q == TICK_W'(OVERSAMPLE - 1));
    assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
    assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
    assign tx_ready  = (state_q == ST_IDLE);
    assign tx_busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_done = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        // The tick counter only runs inside a frame; a tick on the handshake cycle is dropped.
        if (state_q != ST_IDLE && s_tick) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_START;
                    shreg_d = tx_data;
                    tick_d  = '0;
                    bit_d   = '0;
`ifdef UART_PARITY_EN
                    par_d   = ^tx_data ^ parity_odd;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (last_data) begin
                        bit_d = '0;
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // bit_q counts stop bits here; the frame completes on the last tick of the last one.
                if (bit_end) begin
                    if (last_stop) begin
                        tx_done = 1'b1;
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The line level follows the state being entered, so tx is a clean register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx      <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two configurations (8N1/16x and 6-bit, 2 stop, 8x) against a tick-count frame model.
module tb_uart_tx;

`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB_A = 8, SB_A = 1, OS_A = 16;
    localparam int NB_B = 6, SB_B = 2, OS_B = 8;
    localparam int TOT_A = OS_A * (1 + NB_A + PAR + SB_A);
    localparam int TOT_B = OS_B * (1 + NB_B + PAR + SB_B);

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx u_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tick   (s_tick),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (rdy_a),
        .tx       (tx_a),
        .tx_busy  (busy_a),
        .tx_done  (done_a)
`ifdef UART_PARITY_EN
        ,
        .parity_odd (parity_odd)
`endif
    );

    uart_tx #(.DATA_BITS(NB_B), .STOP_BITS(SB_B), .OVERSAMPLE(OS_B)) u_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tick   (s_tick),
        .tx_data  (tx_data[5:0]),
        .tx_valid (tx_valid),
        .tx_ready (rdy_b),
        .tx       (tx_b),
        .tx_busy  (busy_b),
        .tx_done  (done_b)
`ifdef UART_PARITY_EN
        ,
        .parity_odd (parity_odd)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a frame is a list of bit levels; the tick count since the handshake picks the level.
    bit         m_busy [2] = '{1'b0, 1'b0};
    int         m_cnt  [2] = '{0, 0};
    logic [7:0] m_dat  [2] = '{8'h00, 8'h00};
    logic       m_par  [2] = '{1'b0, 1'b0};

    function automatic int nb_of(input int k);  return (k == 0) ? NB_A : NB_B;   endfunction
    function automatic int os_of(input int k);  return (k == 0) ? OS_A : OS_B;   endfunction
    function automatic int tot_of(input int k); return (k == 0) ? TOT_A : TOT_B; endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int nb, input logic podd, input int idx);
        logic p;
        p = podd;
        if (idx == 0) return 1'b0;
        if (idx <= nb) return d[idx-1];
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        if (PAR == 1 && idx == nb + 1) return p;
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int k);
        return m_busy[k] ? frame_bit(m_dat[k], nb_of(k), m_par[k], m_cnt[k] / os_of(k)) : 1'b1;
    endfunction

    function automatic logic exp_done(input int k);
        return m_busy[k] && s_tick && (m_cnt[k] == tot_of(k) - 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) m_busy[k] <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k]) begin
                    if (tx_valid) begin
                        m_busy[k] <= 1'b1;
                        m_cnt[k]  <= 0;
                        m_dat[k]  <= tx_data;
                        m_par[k]  <= parity_odd;
                    end
                end else if (s_tick) begin
                    if (m_cnt[k] == tot_of(k) - 1) m_busy[k] <= 1'b0;
                    else m_cnt[k] <= m_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_tx",   tx_a,   exp_tx(0));
            check("a_rdy",  rdy_a,  !m_busy[0]);
            check("a_busy", busy_a, m_busy[0]);
            check("a_done", done_a, exp_done(0));
            check("b_tx",   tx_b,   exp_tx(1));
            check("b_rdy",  rdy_b,  !m_busy[1]);
            check("b_busy", busy_b, m_busy[1]);
            check("b_done", done_b, exp_done(1));
        end
    end

    // Called in cycle 1 of a frame with s_tick held high; records A's level at each bit start,
    // the cycle of each DUT's first tx_done, and B's run of high cycles ending at its tx_done.
    task automatic record(input int pulse_c, output int d_a, output int d_b,
                          output logic [11:0] lv, output int run_b);
        int run;
        d_a = -1; d_b = -1; lv = '1; run_b = -1; run = 0;
        tx_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c == pulse_c) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            @(negedge clk);
            if ((c - 1) % 16 == 0 && (c - 1) / 16 < 12) lv[(c-1)/16] = tx_a;
            run = tx_b ? run + 1 : 0;
            if (d_a < 0 && done_a) d_a = c;
            if (d_b < 0 && done_b) begin
                d_b   = c;
                run_b = run;
            end
            @(posedge clk); #1;
            tx_valid = 1'b0;
            if (d_a >= 0 && d_b >= 0) break;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int pulse_c, output int d_a, output int d_b,
                             output logic [11:0] lv, output int run_b);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = d;
        s_tick   = 1'b1;
        @(posedge clk); #1;
        record(pulse_c, d_a, d_b, lv, run_b);
    endtask

    initial begin
        int d_a, d_b, rb, mode;
        logic [11:0] lv;
        mode = 0;

        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",   tx_a,   1'b1);
        check("rst_rdy",  rdy_a,  1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        reset_n = 1'b1;

        // 8N1 0x55: alternating levels, done on tick 160, ready the clk after.
        run_frame(8'h55, 0, d_a, d_b, lv, rb);
        check("t1_done_cycle", d_a, 16 * (10 + PAR));
        check("t1_levels", lv[8:0], 9'h0AA);
        check("t1_rdy_after_done", rdy_a, 1'b1);
        check("t1_b_done_cycle", d_b, 8 * (9 + PAR));

        // Back-to-back with tx_valid held: one idle clk between frames.
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 8'hA3; s_tick = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'h0F;
        d_a = -1;
        for (int c = 1; c <= 400 && d_a < 0; c++) begin
            @(negedge clk);
            if (done_a) d_a = c;
            @(posedge clk); #1;
        end
        check("t2_first_done", d_a, TOT_A);
        check("t2_gap_rdy", rdy_a, 1'b1);
        check("t2_gap_tx", tx_a, 1'b1);
        @(posedge clk); #1;
        check("t2_restart_tx", tx_a, 1'b0);
        check("t2_restart_busy", busy_a, 1'b1);
        record(0, d_a, d_b, lv, rb);
        check("t2_levels", lv[8:0], 9'h01E);
        check("t2_done_cycle", d_a, TOT_A);

        // Reset in data bit 4 of 0xE7 (a low bit).
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 8'hE7; s_tick = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (84) @(posedge clk);
        #1;
        check("t3_pre_tx", tx_a, 1'b0);
        reset_n = 1'b0;
        #1;
        check("t3_rst_tx", tx_a, 1'b1);
        check("t3_rst_rdy", rdy_a, 1'b1);
        check("t3_rst_busy", busy_a, 1'b0);
        check("t3_rst_done", done_a, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_frame(8'h3C, 0, d_a, d_b, lv, rb);
        check("t3_next_levels", lv[8:0], 9'h078);
        check("t3_next_done", d_a, TOT_A);

        // 0xFF request in mid-frame must be ignored.
        run_frame(8'h12, 30, d_a, d_b, lv, rb);
        check("t4_levels", lv[8:0], 9'h024);
        check("t4_done_cycle", d_a, TOT_A);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_no_restart", busy_a, 1'b0);
        end

        // Two stop bits at 8x: stop high lasts 16 ticks, done on the 16th.
        parity_odd = 1'b0;
        run_frame(8'h00, 0, d_a, d_b, lv, rb);
        check("t6_b_done_cycle", d_b, TOT_B);
        check("t6_b_stop_run", rb, 16);

`ifdef UART_PARITY_EN
        parity_odd = 1'b0;
        run_frame(8'h07, 0, d_a, d_b, lv, rb);
        check("t5_even_parity", lv[9], 1'b1);
        check("t5_frame_ticks", d_a, 176);
        parity_odd = 1'b1;
        run_frame(8'h07, 0, d_a, d_b, lv, rb);
        check("t5_odd_parity", lv[9], 1'b0);
`endif

        for (int i = 0; i < 24000; i++) begin
            @(posedge clk); #1;
            if (i % 600 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       s_tick = ($urandom_range(0, 3) == 0);
                1:       s_tick = 1'b1;
                default: s_tick = 1'($urandom);
            endcase
            tx_valid   = (mode == 1) ? 1'b1 : ($urandom_range(0, 5) == 0);
            tx_data    = 8'($urandom);
            parity_odd = 1'($urandom);
            reset_n    = ($urandom_range(0, 2499) != 0);
        end
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
